// File: rtl/knn_buf_pkg.sv
// Shared types and defaults for the KNN local-buffer controller.
package knn_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } knn_buf_state_e;

    localparam int KNN_DATA_WIDTH   = 256;
    localparam int KNN_ADDR_WIDTH   = 11;
    localparam int KNN_READ_LATENCY = 2;
    localparam int KNN_FIFO_DEPTH   = 4;
    localparam int KNN_PASS_WIDTH   = 8;

    // The skid FIFO has to hold every read that can be in flight plus one.
    function automatic bit fifo_depth_ok(input int depth, input int latency);
        return depth >= latency + 1;
    endfunction

endpackage

// File: rtl/knn_buf_skid_fifo.sv
// Small output skid FIFO: holds {last, data} entries returned by the buffer.
module knn_buf_skid_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Storage, pointers and occupancy; pushes and pops may share a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (i_pop)
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/knn_local_buf_ctrl.sv
// Fill/replay controller for the per-PE URAM local buffer.
// Optional stall counter output enabled by defining KNN_BUF_PERF_EN.
module knn_local_buf_ctrl
    import knn_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = KNN_DATA_WIDTH,
    parameter int ADDR_WIDTH   = KNN_ADDR_WIDTH,
    parameter int READ_LATENCY = KNN_READ_LATENCY,
    parameter int FIFO_DEPTH   = KNN_FIFO_DEPTH,
    parameter int PASS_WIDTH   = KNN_PASS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [PASS_WIDTH-1:0] num_passes,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [ADDR_WIDTH-1:0] mem_address0,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_d0,
    input  logic [DATA_WIDTH-1:0] mem_q0
`ifdef KNN_BUF_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles
`endif
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CRW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    generate
        if (!fifo_depth_ok(FIFO_DEPTH, READ_LATENCY)) begin : g_bad_depth
            $error("FIFO_DEPTH must be at least READ_LATENCY+1");
        end
    endgenerate

    knn_buf_state_e          r_state, w_state_nxt;
    logic [ADDR_WIDTH:0]     r_num_words;
    logic [PASS_WIDTH-1:0]   r_num_passes, r_pass_cnt;
    logic [ADDR_WIDTH-1:0]   r_wr_cnt, r_rd_addr;
    logic                    r_issue_done;
    logic [READ_LATENCY-1:0] r_vld_pipe, r_last_pipe;

    logic                    w_start_acc, w_wr_beat, w_wr_last, w_rd_last, w_rd_issue;
    logic [CRW-1:0]          w_inflight;
    logic [FCW-1:0]          w_fifo_count;
    logic                    w_fifo_empty, w_pop;
    logic [DATA_WIDTH:0]     w_fifo_data;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_wr_beat   = (r_state == LOAD) && s_tvalid;
    assign w_wr_last   = ({1'b0, r_wr_cnt} == r_num_words - (ADDR_WIDTH+1)'(1));
    assign w_rd_last   = ({1'b0, r_rd_addr} == r_num_words - (ADDR_WIDTH+1)'(1));

    // Reads already issued but not yet returned from the buffer.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            w_inflight = w_inflight + CRW'(r_vld_pipe[i]);
    end

    // Credit: only issue if every outstanding read is guaranteed a FIFO slot.
    assign w_rd_issue = (r_state == SCAN) && !r_issue_done &&
                        ((w_inflight + CRW'(w_fifo_count)) < CRW'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and buffer port drive.
    always_comb begin
        w_state_nxt  = r_state;
        mem_ce0      = 1'b0;
        mem_we0      = 1'b0;
        mem_address0 = '0;
        mem_d0       = '0;
        case (r_state)
            IDLE: if (start) w_state_nxt = (num_words == '0) ? DONE : LOAD;
            LOAD: begin
                if (w_wr_beat) begin
                    mem_ce0      = 1'b1;
                    mem_we0      = 1'b1;
                    mem_address0 = r_wr_cnt;
                    mem_d0       = s_tdata;
                    if (w_wr_last) w_state_nxt = (r_num_passes == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (w_rd_issue) begin
                    mem_ce0      = 1'b1;
                    mem_address0 = r_rd_addr;
                end
                if (r_issue_done && (r_vld_pipe == '0) && w_fifo_empty)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Job parameters, write/read counters and the read-tag pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_words  <= '0;
            r_num_passes <= '0;
            r_pass_cnt   <= '0;
            r_wr_cnt     <= '0;
            r_rd_addr    <= '0;
            r_issue_done <= 1'b0;
            r_vld_pipe   <= '0;
            r_last_pipe  <= '0;
        end else begin
            if (w_start_acc) begin
                r_num_words  <= num_words;
                r_num_passes <= num_passes;
                r_pass_cnt   <= '0;
                r_wr_cnt     <= '0;
                r_rd_addr    <= '0;
                r_issue_done <= 1'b0;
            end
            if (w_wr_beat) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_rd_issue) begin
                if (w_rd_last) begin
                    r_rd_addr  <= '0;
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                    if (r_pass_cnt == r_num_passes - PASS_WIDTH'(1)) r_issue_done <= 1'b1;
                end else begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                end
            end
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
            r_vld_pipe[0]  <= w_rd_issue;
            r_last_pipe[0] <= w_rd_issue && w_rd_last;
        end
    end

    knn_buf_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_vld_pipe[READ_LATENCY-1]),
        .i_data  ({r_last_pipe[READ_LATENCY-1], mem_q0}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign m_tvalid = !w_fifo_empty;
    assign m_tdata  = m_tvalid ? w_fifo_data[DATA_WIDTH-1:0] : '0;
    assign m_tlast  = m_tvalid && w_fifo_data[DATA_WIDTH];
    assign w_pop    = m_tvalid && m_tready;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign s_tready = (r_state == LOAD);

`ifdef KNN_BUF_PERF_EN
    logic [31:0] r_perf_stall;

    // Backpressure stall counter, saturating, restarted by each job.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_perf_stall <= '0;
        else if (w_start_acc)
            r_perf_stall <= '0;
        else if ((r_state == SCAN) && m_tvalid && !m_tready && (r_perf_stall != '1))
            r_perf_stall <= r_perf_stall + 1'b1;
    end

    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_knn_local_buf_ctrl.sv
// Self-checking bench for knn_local_buf_ctrl with a behavioural URAM model.
module tb_knn_local_buf_ctrl;
    localparam int DW = 256;
    localparam int AW = 11;
    localparam int RL = 2;
    localparam int FD = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW:0]   num_words;
    logic [PW-1:0] num_passes;
    logic          busy, done;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [AW-1:0] mem_address0;
    logic          mem_ce0, mem_we0;
    logic [DW-1:0] mem_d0;
    logic [DW-1:0] mem_q0 = '0;
`ifdef KNN_BUF_PERF_EN
    logic [31:0]   perf_stall_cycles;
`endif

    knn_local_buf_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
        .num_passes(num_passes), .busy(busy), .done(done),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
        .mem_d0(mem_d0), .mem_q0(mem_q0)
`ifdef KNN_BUF_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // URAM model: registered read, two cycles from ce0 to valid q0.
    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] q_s1 = '0;
    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_we0) mem[mem_address0] <= mem_d0;
            else         q_s1 <= mem[mem_address0];
        end
        mem_q0 <= q_s1;
    end

    typedef struct {
        int nw;
        int np;
        bit rdy_rand;
        bit gaps;
        bit spam;
    } vec_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] exp_mem [0:2047];
    vec_t          vecs [7];

    int checks = 0, errors = 0, cyc = 0;
    int rd_seen, wr_seen, done_seen, trdy_seen, pops, outst, max_out;
    int first_rd, first_vld, first_pop, last_pop, start_cyc, done_cyc;
    int cur_nw, exp_rd_addr, lcyc;
    bit hs, rdy_rand;
    logic rdy_val;

    function automatic logic [DW-1:0] pat(input int tid, input int idx);
        return {32'(tid), 192'(idx + 1) * 192'h9E3779B97F4A7C15, 32'(32'hA0 + idx)};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        cyc++;
        hs = s_tvalid && s_tready;
        if (s_tready) trdy_seen++;
        if (start && start_cyc < 0) start_cyc = cyc;
        if (mem_ce0 && mem_we0) begin
            chk("wr_addr", mem_address0, DW'(wr_seen));
            chk("wr_data", mem_d0, exp_mem[wr_seen % 2048]);
            wr_seen++;
        end
        if (mem_ce0 && !mem_we0) begin
            if (first_rd < 0) first_rd = cyc;
            chk("rd_addr", mem_address0, DW'(exp_rd_addr));
            exp_rd_addr = (exp_rd_addr == cur_nw - 1) ? 0 : exp_rd_addr + 1;
            rd_seen++;
            outst++;
        end
        if (m_tvalid && first_vld < 0) first_vld = cyc;
        if (m_tvalid && m_tready) begin
            pops++;
            outst--;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra got %0h want none", m_tdata);
            end else begin
                e = sbq.pop_front();
                chk("sb_data", m_tdata, e.data);
                chk("sb_last", m_tlast, e.last);
            end
        end
        if (outst > max_out) max_out = outst;
        if (done) begin
            if (done_seen == 0) done_cyc = cyc;
            done_seen++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        m_tready = rdy_rand ? 1'($urandom % 2) : rdy_val;
    endtask

    task automatic clear_stats(input int nw);
        rd_seen = 0; wr_seen = 0; done_seen = 0; trdy_seen = 0; pops = 0;
        outst = 0; max_out = 0; first_rd = -1; first_vld = -1; first_pop = -1;
        last_pop = -1; start_cyc = -1; done_cyc = -1; cur_nw = nw; exp_rd_addr = 0;
        lcyc = 0;
        sbq.delete();
    endtask

    // Start a job and stream its load data; returns after the final load beat.
    task automatic start_and_load(input int tid, input vec_t v);
        int idx, guard;
        for (int i = 0; i < v.nw; i++) exp_mem[i] = pat(tid, i);
        for (int p = 0; p < v.np; p++)
            for (int i = 0; i < v.nw; i++) sbq.push_back({i == v.nw - 1, exp_mem[i]});
        num_words  = (AW+1)'(v.nw);
        num_passes = PW'(v.np);
        start = 1'b1;
        tick();
        chk("busy_start", busy, 1'b1);
        start = v.spam;
        if (v.spam) begin
            num_words  = 12'd7;
            num_passes = 8'd9;
        end
        idx = 0;
        guard = 0;
        while (idx < v.nw && guard < 20000) begin
            s_tvalid = v.gaps ? 1'($urandom % 2) : 1'b1;
            s_tdata  = exp_mem[idx];
            tick();
            guard++;
            lcyc++;
            if (hs) idx++;
        end
        s_tvalid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_seen == 0 && guard < 40000) begin
            tick();
            guard++;
        end
        tick();
        tick();
    endtask

    task automatic run_vec(input int tid, input vec_t v);
        clear_stats(v.nw);
        rdy_rand = v.rdy_rand;
        rdy_val  = 1'b1;
        start_and_load(tid, v);
        wait_done();
        chk("done_cnt", DW'(done_seen), DW'(1));
        chk("writes", DW'(wr_seen), DW'(v.nw));
        chk("reads", DW'(rd_seen), DW'(v.nw * v.np));
        chk("sb_left", DW'(sbq.size()), DW'(0));
        chk("busy_end", busy, 1'b0);
        chk("trdy_cycles", DW'(trdy_seen), DW'(lcyc));
        chk("fifo_bound", max_out <= FD, 1'b1);
        chk("vld_seen", first_vld >= 0, rd_seen > 0);
        if (rd_seen > 0) chk("first_lat", DW'(first_vld - first_rd), DW'(RL + 1));
        if (!v.rdy_rand && pops > 0) chk("thruput", DW'(last_pop - first_pop + 1), DW'(pops));
        if (v.nw == 0) chk("done_lat", DW'(done_cyc - start_cyc), DW'(1));
        sbq.delete();
    endtask

    initial begin
        int guard;
        vecs[0] = '{4,    1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3,    2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2048, 3, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{0,    1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{5,    0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1,    4, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{7,    2, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0; start = 1'b0; num_words = '0; num_passes = '0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0; rdy_rand = 1'b0; rdy_val = 1'b1;
        clear_stats(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {busy, done, s_tready, m_tvalid, m_tlast, mem_ce0, mem_we0}, '0);
        chk("rst_bus", {mem_address0, mem_d0, m_tdata}, '0);
        reset_n = 1'b1;
        tick();

        for (int t = 0; t < 7; t++) run_vec(t, vecs[t]);

        // Abort mid-SCAN with two reads in flight, then run a fresh job.
        clear_stats(8);
        rdy_rand = 1'b0;
        rdy_val  = 1'b0;
        m_tready = 1'b0;
        start_and_load(20, '{8, 2, 1'b0, 1'b0, 1'b0});
        guard = 0;
        while (rd_seen < 2 && guard < 100) begin
            tick();
            guard++;
        end
        chk("mid_reads", DW'(rd_seen), DW'(2));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {busy, done, s_tready, m_tvalid, m_tlast, mem_ce0, mem_we0}, '0);
        chk("mid_rst_bus", {mem_address0, mem_d0, m_tdata}, '0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", {busy, m_tvalid, mem_ce0}, '0);
        run_vec(21, '{8, 1, 1'b0, 1'b0, 1'b0});

`ifdef KNN_BUF_PERF_EN
        clear_stats(4);
        rdy_rand = 1'b0;
        rdy_val  = 1'b0;
        m_tready = 1'b0;
        start_and_load(30, '{4, 1, 1'b0, 1'b0, 1'b0});
        guard = 0;
        while (first_vld < 0 && guard < 100) begin
            tick();
            guard++;
        end
        for (int k = 0; k < 9; k++) begin
            if (k == 8) rdy_val = 1'b1;
            tick();
        end
        wait_done();
        chk("perf_stall", DW'(perf_stall_cycles), DW'(10));
        chk("perf_sb_left", DW'(sbq.size()), DW'(0));
        clear_stats(0);
        rdy_val = 1'b1;
        num_words = '0;
        num_passes = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("perf_clear", DW'(perf_stall_cycles), DW'(0));
        wait_done();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_local_buf_ctrl.md
Name: knn_local_buf_ctrl

Overview:
Controller directly upstream and downstream of the per-PE URAM local buffer (256-bit x 2048, single address port, ce/we, registered read). Fills the buffer from an input stream of search-space words, then replays the stored words NUM_PASSES times as an output stream to the distance-compute pipeline. Absorbs the fixed memory read latency behind a small credit-managed skid FIFO so output backpressure never loses data.

Parameters:
DATA_WIDTH, 256, word width; matches buffer DataWidth
ADDR_WIDTH, 11, buffer address width
READ_LATENCY, 2, cycles from ce0 (read) to valid q0
FIFO_DEPTH, 4, output skid FIFO entries; must be >= READ_LATENCY+1
PASS_WIDTH, 8, width of pass counter

Ports:
clk  in  1  kernel clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins load, ignored unless IDLE
num_words  in  ADDR_WIDTH+1  words to load/replay (0..2048), sampled at start
num_passes  in  PASS_WIDTH  replay passes, sampled at start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
s_tdata  in  DATA_WIDTH  load data
s_tvalid  in  1  load data valid
s_tready  out  1  high only in LOAD
m_tdata  out  DATA_WIDTH  replayed word
m_tvalid  out  1  replay valid
m_tready  in  1  downstream ready
m_tlast  out  1  last word of current pass
mem_address0  out  ADDR_WIDTH  buffer address
mem_ce0  out  1  buffer enable
mem_we0  out  1  buffer write enable
mem_d0  out  DATA_WIDTH  buffer write data
mem_q0  in  DATA_WIDTH  buffer read data

Behaviour:
- Reset (async, reset_n low): state IDLE; busy, done, s_tready, m_tvalid, m_tlast, mem_ce0, mem_we0 = 0; mem_address0, mem_d0, m_tdata = 0; counters, credit, FIFO pointers cleared. Buffer contents untouched. Reset mid-operation aborts immediately; in-flight reads discarded.
- States: IDLE -> LOAD (start) -> SCAN -> DONE -> IDLE.
- IDLE: start latches num_words/num_passes, busy=1. num_words==0 -> straight to DONE.
- LOAD: s_tready=1. Each s_tvalid&s_tready beat drives mem_ce0=1, mem_we0=1, mem_address0=wr_cnt, mem_d0=s_tdata combinationally same cycle; wr_cnt++. After beat num_words-1 -> SCAN (num_passes==0 -> DONE).
- SCAN: read issued (mem_ce0=1, mem_we0=0, address=rd_addr) when inflight+fifo_count < FIFO_DEPTH and issue not finished. rd_addr wraps to 0 after num_words-1; pass_cnt++ on wrap; issue stops after num_passes*num_words reads. READ_LATENCY-deep valid/last shift register tags each read; at tail, mem_q0 and last flag pushed into FIFO. Enqueue and dequeue may occur same cycle. FIFO head drives m_tdata/m_tvalid/m_tlast. Credit guarantees FIFO never overflows. Leaves SCAN when all reads issued, pipeline empty, FIFO empty.
- Minimum latency start-of-SCAN to first m_tvalid: READ_LATENCY+1 cycles. Steady state 1 word/cycle with m_tready=1.
- DONE: done=1 for one cycle, busy=0 on next cycle, -> IDLE.
- start while busy ignored. mem_ce0 low in IDLE/DONE and on non-issuing SCAN cycles.

Optional Feature:
KNN_BUF_PERF_EN: defined -> extra output perf_stall_cycles [31:0], counts SCAN cycles with m_tvalid=1 & m_tready=0, cleared on accepted start, saturates at 2^32-1, reset to 0. Undefined -> port and counter absent; behaviour otherwise identical.

Decomposition:
- Package knn_buf_pkg: state enum (IDLE, LOAD, SCAN, DONE), default DATA_WIDTH/ADDR_WIDTH/READ_LATENCY constants, FIFO_DEPTH legality check.
- One sub-module: knn_buf_skid_fifo (DATA_WIDTH+1 wide, FIFO_DEPTH entries, push/pop/count, async active-low reset).

Test Plan:
- num_words=4, num_passes=1, data 0xA0..0xA3, m_tready=1 -> writes at addr 0..3; outputs A0,A1,A2,A3, m_tlast on A3 only; done pulse once.
- num_words=3, num_passes=2 -> stream A0,A1,A2,A0,A1,A2; m_tlast on both A2; 6 reads total.
- Random m_tready (50%) and s_tvalid gaps, num_words=2048, passes=3 -> no drop/duplicate, order exact, FIFO never exceeds FIFO_DEPTH, address wraps 2047->0.
- num_words=0 -> done 1 cycle after start, no mem_ce0, s_tready never high; num_passes=0 -> load only, no m_tvalid.
- reset_n low mid-SCAN with 2 reads in flight -> all outputs 0 immediately; new start after release replays from addr 0 without reload corruption.
- With KNN_BUF_PERF_EN, m_tready held low 10 cycles while m_tvalid=1 -> perf_stall_cycles=10; cleared to 0 on next start.
